// File: rtl/aes_in_loader_if.sv
// Word-stream input and round-0 output bundle of the AES front-end loader.
// The loader is the slave; the upstream/downstream environment is the master.
interface aes_in_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_ready;
  logic         en;
  logic [127:0] state;
  logic [127:0] key;
  logic [3:0]   num;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, en, state, key, num
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, en, state, key, num
  );
endinterface

// File: rtl/aes_in_loader.sv
// AES front-end: assembles plaintext and key from a 32-bit word stream, applies
// the initial AddRoundKey and holds the result for the first round register.
module aes_in_loader #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  aes_in_loader_if.slave    bus,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int WCNT_W = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(2 * WORDS_PER_BLOCK - 1);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              asm_full_q, asm_full_d;
  logic [127:0]      pt_q, pt_d;
  logic [127:0]      kbuf_q, kbuf_d;
  logic              en_q, en_d;
  logic [127:0]      state_q, state_d;
  logic [127:0]      key_q, key_d;
  logic [3:0]        num_q, num_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

  logic accept;
  logic transfer;

  // Stall only when a finished block waits behind an occupied, non-draining slot.
  assign bus.in_ready = !asm_full_q || !en_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign transfer     = asm_full_q && (!en_q || bus.out_ready);

  always_comb begin
    wcnt_d     = wcnt_q;
    asm_full_d = asm_full_q;
    pt_d       = pt_q;
    kbuf_d     = kbuf_q;
    en_d       = en_q;
    state_d    = state_q;
    key_d      = key_q;
    num_d      = num_q;
    blk_cnt_d  = blk_cnt_q;

    if (flush) begin
      wcnt_d     = '0;
      asm_full_d = 1'b0;
      en_d       = 1'b0;
      state_d    = '0;
      key_d      = '0;
      num_d      = '0;
    end else begin
      if (transfer) begin
        state_d    = pt_q ^ kbuf_q;
        key_d      = kbuf_q;
        num_d      = 4'h1;
        en_d       = 1'b1;
        asm_full_d = 1'b0;
        blk_cnt_d  = blk_cnt_q + CNT_W'(1);
      end else if (en_q && bus.out_ready) begin
        en_d = 1'b0;
      end

      // A word accepted alongside a transfer is always word 0, so it never
      // disturbs the key buffer the transfer is reading.
      if (accept) begin
        if (!wcnt_q[2]) begin
          pt_d[{wcnt_q[1:0], 5'd0} +: 32] = bus.in_data;
        end else begin
          kbuf_d[{wcnt_q[1:0], 5'd0} +: 32] = bus.in_data;
        end
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (wcnt_q == LAST_WORD) begin
          asm_full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q     <= '0;
      asm_full_q <= 1'b0;
      pt_q       <= '0;
      kbuf_q     <= '0;
      en_q       <= 1'b0;
      state_q    <= '0;
      key_q      <= '0;
      num_q      <= '0;
      blk_cnt_q  <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      asm_full_q <= asm_full_d;
      pt_q       <= pt_d;
      kbuf_q     <= kbuf_d;
      en_q       <= en_d;
      state_q    <= state_d;
      key_q      <= key_d;
      num_q      <= num_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign bus.en    = en_q;
  assign bus.state = state_q;
  assign bus.key   = key_q;
  assign bus.num   = num_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_aes_in_loader.sv
// Directed bench for aes_in_loader: table of reference blocks plus hand-written
// sequences for backpressure, overlap, flush, async reset and counter wrap.
module tb_aes_in_loader;

  typedef struct packed {
    logic [7:0][31:0] w;
    logic [127:0]     expState;
    logic [127:0]     expKey;
  } vec_t;

  logic clk;
  logic rst;
  logic flush;
  logic [15:0] blkCnt;
  logic [1:0]  blkCnt2;

  int testsRun;
  int testsFailed;
  int expBlk;
  vec_t vecs[3];

  aes_in_loader_if ifc ();
  aes_in_loader_if ifc2 ();

  assign ifc2.in_valid  = ifc.in_valid;
  assign ifc2.in_data   = ifc.in_data;
  assign ifc2.out_ready = ifc.out_ready;

  aes_in_loader #(.WORDS_PER_BLOCK(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifc.slave), .blk_cnt(blkCnt)
  );

  aes_in_loader #(.WORDS_PER_BLOCK(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifc2.slave), .blk_cnt(blkCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one word, optionally after idle cycles, and returns once it is accepted.
  task automatic applyStimulus(input logic [31:0] data, input int gaps);
    bit accepted;
    accepted = 1'b0;
    repeat (gaps) begin
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b1;
    ifc.in_data  = data;
    for (int i = 0; i < 50; i++) begin
      if (ifc.in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic sendWords(input int idx, input int first, input int last, input int maxGap);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[idx].w[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
  endtask

  task automatic checkBlock(input string tag, input int idx);
    checkOutput({tag, " en"},    128'(ifc.en),    128'(1));
    checkOutput({tag, " state"}, ifc.state,       vecs[idx].expState);
    checkOutput({tag, " key"},   ifc.key,         vecs[idx].expKey);
    checkOutput({tag, " num"},   128'(ifc.num),   128'(4'h1));
    checkOutput({tag, " blk_cnt"}, 128'(blkCnt),  128'(expBlk[15:0]));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #7;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expBlk      = 0;

    vecs[0].w = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                 32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
    vecs[0].expState = 128'hf0e0d0c0b0a090807060504030201000;
    vecs[0].expKey   = 128'h0f0e0d0c0b0a09080706050403020100;
    vecs[1].w = {32'h00000000, 32'h0f0f0f0f, 32'h9abcdef0, 32'h12345678,
                 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
    vecs[1].expState = 128'hfffffffff0f0f0f06543210fedcba987;
    vecs[1].expKey   = 128'h000000000f0f0f0f9abcdef012345678;
    vecs[2].w = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111,
                 32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
    vecs[2].expState = 128'h0;
    vecs[2].expKey   = 128'h88888888444444442222222211111111;

    rst           = 1'b1;
    flush         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    #12;
    checkOutput("reset en",      128'(ifc.en),  128'(0));
    checkOutput("reset state",   ifc.state,     128'(0));
    checkOutput("reset key",     ifc.key,       128'(0));
    checkOutput("reset num",     128'(ifc.num), 128'(0));
    checkOutput("reset blk_cnt", 128'(blkCnt),  128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", 128'(ifc.in_ready), 128'(1));

    // Table pass: every reference block with a free output slot.
    for (int v = 0; v < 3; v++) begin
      sendWords(v, 0, 7, 0);
      checkOutput($sformatf("vec%0d latency", v), 128'(ifc.en), 128'(0));
      @(posedge clk);
      #1;
      expBlk++;
      checkBlock($sformatf("vec%0d", v), v);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d drain en", v), 128'(ifc.en), 128'(0));
      checkOutput($sformatf("vec%0d drain state held", v), ifc.state, vecs[v].expState);
    end

    // Backpressure: two blocks with the slot blocked.
    ifc.out_ready = 1'b0;
    sendWords(0, 0, 7, 0);
    @(posedge clk);
    #1;
    expBlk++;
    checkBlock("bp first", 0);
    sendWords(1, 0, 7, 0);
    checkOutput("bp stall in_ready", 128'(ifc.in_ready), 128'(0));
    checkOutput("bp hold state", ifc.state, vecs[0].expState);
    checkOutput("bp hold en", 128'(ifc.en), 128'(1));
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    expBlk++;
    checkBlock("bp second", 1);
    checkOutput("bp in_ready back", 128'(ifc.in_ready), 128'(1));
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Overlap: next block's word 0 accepted on the transfer edge.
    sendWords(2, 0, 7, 0);
    applyStimulus(vecs[0].w[0], 0);
    expBlk++;
    checkBlock("overlap first", 2);
    checkOutput("overlap col0", 128'(dut.pt_q[31:0]), 128'(32'h33221100));
    sendWords(0, 1, 7, 0);
    @(posedge clk);
    #1;
    expBlk++;
    checkBlock("overlap second", 0);

    // Flush after five words, then a clean block.
    sendWords(1, 0, 4, 0);
    flush        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 32'hdeadbeef;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    checkOutput("flush en", 128'(ifc.en), 128'(0));
    checkOutput("flush wcnt", 128'(dut.wcnt_q), 128'(0));
    checkOutput("flush blk_cnt", 128'(blkCnt), 128'(expBlk[15:0]));
    sendWords(0, 0, 7, 0);
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    expBlk++;
    checkBlock("post flush", 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush slot en",    128'(ifc.en),  128'(0));
    checkOutput("flush slot state", ifc.state,     128'(0));
    checkOutput("flush slot key",   ifc.key,       128'(0));
    checkOutput("flush slot num",   128'(ifc.num), 128'(0));
    checkOutput("flush slot blk_cnt", 128'(blkCnt), 128'(expBlk[15:0]));

    // Async reset mid-cycle with a held block and three buffered words.
    sendWords(1, 0, 7, 0);
    @(posedge clk);
    #1;
    sendWords(0, 0, 2, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst en",      128'(ifc.en),  128'(0));
    checkOutput("arst state",   ifc.state,     128'(0));
    checkOutput("arst key",     ifc.key,       128'(0));
    checkOutput("arst num",     128'(ifc.num), 128'(0));
    checkOutput("arst blk_cnt", 128'(blkCnt),  128'(0));
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expBlk = 0;
    ifc.out_ready = 1'b1;
    checkOutput("arst in_ready", 128'(ifc.in_ready), 128'(1));
    sendWords(2, 0, 7, 0);
    @(posedge clk);
    #1;
    expBlk++;
    checkBlock("post arst", 2);

    // Counter wrap on the 2-bit instance with random idle gaps.
    pulseReset();
    for (int b = 0; b < 5; b++) begin
      sendWords(b % 3, 0, 7, 2);
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap blk%0d cnt", b), 128'(blkCnt2), 128'((b + 1) % 4));
      checkOutput($sformatf("wrap blk%0d state", b), ifc2.state, vecs[b % 3].expState);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
